// File: rtl/trap_controller.sv
// trap_controller: user-mode trap sequencer.
// Takes synchronous exceptions, URET and edge-latched external/timer interrupts.
// It writes UEPC/UCAUSE/UTVAL and redirects the fetch PC.
// Optional feature: define VECTORED_INT_EN for vectored interrupt targets when UTVEC mode = 2'b01.
//
// Handshake: iExcReq is a level request that the core holds while oStall=1.
// It is sampled only in IDLE. oRegWriteSimu and oPCRedirect are one-cycle
// strobes with no back-pressure. oStall is high for every non-IDLE cycle.
module trap_controller (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iExcReq,
    input  logic [4:0]  iExcCause,
    input  logic [31:0] iExcTval,
    input  logic [31:0] iPC,
    input  logic        iUret,
    input  logic        iExtIrq,
    input  logic        iTimerIrq,
    input  logic [31:0] iUSTATUS,
    input  logic [31:0] iUTVEC,
    input  logic [31:0] iUEPC,
    output logic        oRegWriteSimu,
    output logic [31:0] oWriteDataUEPC,
    output logic [31:0] oWriteDataUCAUSE,
    output logic [31:0] oWriteDataUTVAL,
    output logic        oPCRedirect,
    output logic [31:0] oRedirectPC,
    output logic        oStall,
    output logic        oInHandler,
    output logic [1:0]  oDbgState
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_RET      = 2'd3
    } state_e;

    state_e      state_q;
    logic        ext_prev_q, tmr_prev_q;
    logic        pend_ext_q, pend_tmr_q;
    logic        pend_ext_d, pend_tmr_d;
    logic        reg_write_q, redirect_q, stall_q, in_handler_q;
    logic [31:0] uepc_q, ucause_q, utval_q, redirect_pc_q;

    logic        in_idle, irq_allowed, rise_ext, rise_tmr;
    logic        take_exc, take_uret, take_ext, take_tmr;
    logic [31:0] trap_base, vec_offset, trap_target;

    // Only the UIE bit of USTATUS matters here.
    logic unused_ustatus;
    assign unused_ustatus = ^iUSTATUS[31:1];

    // Request arbitration: exception > URET > external > timer, IDLE only.
    always_comb begin
        in_idle     = (state_q == ST_IDLE);
        irq_allowed = iUSTATUS[0] & ~in_handler_q;
        rise_ext    = iExtIrq & ~ext_prev_q;
        rise_tmr    = iTimerIrq & ~tmr_prev_q;
        take_exc    = in_idle & iExcReq;
        take_uret   = in_idle & ~iExcReq & iUret;
        take_ext    = in_idle & ~iExcReq & ~iUret & irq_allowed & pend_ext_q;
        take_tmr    = in_idle & ~iExcReq & ~iUret & irq_allowed & ~pend_ext_q & pend_tmr_q;
        // A fresh edge in the same cycle as a take keeps the pending bit set.
        pend_ext_d  = rise_ext | (pend_ext_q & ~take_ext);
        pend_tmr_d  = rise_tmr | (pend_tmr_q & ~take_tmr);
    end

    // Handler target: UTVEC base, plus a per-cause offset for vectored interrupts.
    always_comb begin
        trap_base  = iUTVEC & 32'hFFFF_FFFC;
        vec_offset = 32'd0;
`ifdef VECTORED_INT_EN
        // UCAUSE[31] marks an interrupt. The cause code times 4 gives the vector slot.
        if (ucause_q[31] && (iUTVEC[1:0] == 2'b01)) begin
            vec_offset = {25'd0, ucause_q[4:0], 2'b00};
        end
`endif
        trap_target = trap_base + vec_offset;
    end

    // Trap FSM with registered outputs, edge detectors and pending bits.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q       <= ST_IDLE;
            ext_prev_q    <= 1'b0;
            tmr_prev_q    <= 1'b0;
            pend_ext_q    <= 1'b0;
            pend_tmr_q    <= 1'b0;
            reg_write_q   <= 1'b0;
            redirect_q    <= 1'b0;
            stall_q       <= 1'b0;
            in_handler_q  <= 1'b0;
            uepc_q        <= 32'd0;
            ucause_q      <= 32'd0;
            utval_q       <= 32'd0;
            redirect_pc_q <= 32'd0;
        end else begin
            ext_prev_q <= iExtIrq;
            tmr_prev_q <= iTimerIrq;
            pend_ext_q <= pend_ext_d;
            pend_tmr_q <= pend_tmr_d;
            case (state_q)
                ST_IDLE: begin
                    if (take_exc || take_ext || take_tmr) begin
                        state_q     <= ST_CAPTURE;
                        stall_q     <= 1'b1;
                        reg_write_q <= 1'b1;
                        uepc_q      <= iPC;
                        if (take_exc) begin
                            ucause_q <= {27'd0, iExcCause};
                            utval_q  <= iExcTval;
                        end else if (take_ext) begin
                            ucause_q <= 32'h8000_0008;
                            utval_q  <= 32'd0;
                        end else begin
                            ucause_q <= 32'h8000_0004;
                            utval_q  <= 32'd0;
                        end
                    end else if (take_uret) begin
                        state_q       <= ST_RET;
                        stall_q       <= 1'b1;
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= iUEPC;
                    end
                end
                ST_CAPTURE: begin
                    state_q       <= ST_REDIRECT;
                    reg_write_q   <= 1'b0;
                    redirect_q    <= 1'b1;
                    redirect_pc_q <= trap_target;
                end
                ST_REDIRECT: begin
                    state_q      <= ST_IDLE;
                    redirect_q   <= 1'b0;
                    stall_q      <= 1'b0;
                    in_handler_q <= 1'b1;
                end
                ST_RET: begin
                    state_q      <= ST_IDLE;
                    redirect_q   <= 1'b0;
                    stall_q      <= 1'b0;
                    in_handler_q <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign oRegWriteSimu    = reg_write_q;
    assign oWriteDataUEPC   = uepc_q;
    assign oWriteDataUCAUSE = ucause_q;
    assign oWriteDataUTVAL  = utval_q;
    assign oPCRedirect      = redirect_q;
    assign oRedirectPC      = redirect_pc_q;
    assign oStall           = stall_q;
    assign oInHandler       = in_handler_q;
    assign oDbgState        = state_q;

endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: directed scenarios plus randomized traffic for trap_controller.
// A transaction-level reference model predicts CSR writes and redirects into exp_q.
// A negedge monitor pops exp_q whenever the DUT strobes an output.
module tb_trap_controller;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic        iExcReq = 1'b0;
    logic [4:0]  iExcCause = '0;
    logic [31:0] iExcTval = '0;
    logic [31:0] iPC = '0;
    logic        iUret = 1'b0;
    logic        iExtIrq = 1'b0;
    logic        iTimerIrq = 1'b0;
    logic [31:0] iUSTATUS = '0;
    logic [31:0] iUTVEC = '0;
    logic [31:0] iUEPC = '0;
    logic        oRegWriteSimu;
    logic [31:0] oWriteDataUEPC, oWriteDataUCAUSE, oWriteDataUTVAL;
    logic        oPCRedirect;
    logic [31:0] oRedirectPC;
    logic        oStall, oInHandler;
    logic [1:0]  oDbgState;

    trap_controller dut (
        .iCLK(iCLK), .iRST(iRST), .iExcReq(iExcReq), .iExcCause(iExcCause),
        .iExcTval(iExcTval), .iPC(iPC), .iUret(iUret), .iExtIrq(iExtIrq),
        .iTimerIrq(iTimerIrq), .iUSTATUS(iUSTATUS), .iUTVEC(iUTVEC), .iUEPC(iUEPC),
        .oRegWriteSimu(oRegWriteSimu), .oWriteDataUEPC(oWriteDataUEPC),
        .oWriteDataUCAUSE(oWriteDataUCAUSE), .oWriteDataUTVAL(oWriteDataUTVAL),
        .oPCRedirect(oPCRedirect), .oRedirectPC(oRedirectPC), .oStall(oStall),
        .oInHandler(oInHandler), .oDbgState(oDbgState)
    );

    // ---------------- clock ----------------
    initial forever #5 iCLK = ~iCLK;

    // ---------------- scoreboard state ----------------
    // Entry: {is_redirect, a, b, c}. Write = {0, uepc, ucause, utval}. Redirect = {1, pc, 64'b0}.
    logic [96:0] exp_q[$];
    logic [31:0] obs_cause_q[$];
    logic [31:0] obs_redir_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag_unexpected(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got pulse expected none", name);
    endtask

    // ---------------- reference model ----------------
    // A trap holds the core for two cycles and enters the handler afterwards.
    // URET holds it for one cycle and leaves the handler.
    int m_busy = 0;
    bit m_handler = 0, m_next_handler = 0;
    bit m_pend_e = 0, m_pend_t = 0, m_prev_e = 0, m_prev_t = 0;
    bit m_rise_e, m_rise_t, m_take_e, m_take_t;

    function automatic logic [31:0] exp_target(input logic [31:0] tvec, input bit irq, input int code);
        logic [31:0] base;
        base = tvec & ~32'd3;
`ifdef VECTORED_INT_EN
        if (irq && tvec[1:0] == 2'b01) return base + 32'(4 * code);
`endif
        return base;
    endfunction

    task automatic push_trap(input logic [31:0] pc, input logic [31:0] cause,
                             input logic [31:0] tval, input bit irq, input int code);
        exp_q.push_back({1'b0, pc, cause, tval});
        exp_q.push_back({1'b1, exp_target(iUTVEC, irq, code), 64'd0});
        m_busy = 2;
        m_next_handler = 1;
    endtask

    always @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            m_busy = 0; m_handler = 0; m_next_handler = 0;
            m_pend_e = 0; m_pend_t = 0; m_prev_e = 0; m_prev_t = 0;
            exp_q.delete();
        end else begin
            m_rise_e = iExtIrq && !m_prev_e;
            m_rise_t = iTimerIrq && !m_prev_t;
            m_take_e = 0;
            m_take_t = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_handler = m_next_handler;
            end else if (iExcReq) begin
                push_trap(iPC, {27'd0, iExcCause}, iExcTval, 0, 0);
            end else if (iUret) begin
                exp_q.push_back({1'b1, iUEPC, 64'd0});
                m_busy = 1;
                m_next_handler = 0;
            end else if (iUSTATUS[0] && !m_handler && m_pend_e) begin
                push_trap(iPC, 32'h8000_0008, 32'd0, 1, 8);
                m_take_e = 1;
            end else if (iUSTATUS[0] && !m_handler && m_pend_t) begin
                push_trap(iPC, 32'h8000_0004, 32'd0, 1, 4);
                m_take_t = 1;
            end
            m_pend_e = m_rise_e || (m_pend_e && !m_take_e);
            m_pend_t = m_rise_t || (m_pend_t && !m_take_t);
            m_prev_e = iExtIrq;
            m_prev_t = iTimerIrq;
        end
    end

    // ---------------- monitor ----------------
    logic [96:0] e;
    always @(negedge iCLK) begin
        if (!iRST) begin
            check("rst_regwrite", {31'd0, oRegWriteSimu}, 32'd0);
            check("rst_redirect", {31'd0, oPCRedirect}, 32'd0);
            check("rst_stall", {31'd0, oStall}, 32'd0);
            check("rst_in_handler", {31'd0, oInHandler}, 32'd0);
            check("rst_uepc", oWriteDataUEPC, 32'd0);
            check("rst_ucause", oWriteDataUCAUSE, 32'd0);
            check("rst_utval", oWriteDataUTVAL, 32'd0);
            check("rst_redirect_pc", oRedirectPC, 32'd0);
            check("rst_state", {30'd0, oDbgState}, 32'd0);
        end else begin
            check("stall", {31'd0, oStall}, {31'd0, m_busy != 0});
            check("in_handler", {31'd0, oInHandler}, {31'd0, m_handler});
            if (oRegWriteSimu) begin
                if (exp_q.size() == 0 || exp_q[0][96]) begin
                    flag_unexpected("unexpected_csr_write");
                end else begin
                    e = exp_q.pop_front();
                    check("uepc", oWriteDataUEPC, e[95:64]);
                    check("ucause", oWriteDataUCAUSE, e[63:32]);
                    check("utval", oWriteDataUTVAL, e[31:0]);
                    obs_cause_q.push_back(oWriteDataUCAUSE);
                end
            end
            if (oPCRedirect) begin
                if (exp_q.size() == 0 || !exp_q[0][96]) begin
                    flag_unexpected("unexpected_redirect");
                end else begin
                    e = exp_q.pop_front();
                    check("redirect_pc", oRedirectPC, e[95:64]);
                    obs_redir_q.push_back(oRedirectPC);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    task automatic do_reset();
        @(negedge iCLK);
        #2 iRST = 1'b0;
        iExcReq = 0; iUret = 0; iExtIrq = 0; iTimerIrq = 0; iUSTATUS = 0;
        tick(2);
        #2 iRST = 1'b1;
        obs_cause_q.delete();
        obs_redir_q.delete();
    endtask

    task automatic pulse_exc(input logic [4:0] cause, input logic [31:0] tval, input logic [31:0] pc);
        @(negedge iCLK);
        iExcReq = 1; iExcCause = cause; iExcTval = tval; iPC = pc;
        @(negedge iCLK);
        iExcReq = 0;
    endtask

    task automatic do_uret(input logic [31:0] epc);
        @(negedge iCLK);
        iUret = 1; iUEPC = epc;
        @(negedge iCLK);
        iUret = 0;
    endtask

    task automatic expect_causes(input string name, input logic [31:0] c0, input logic [31:0] c1, input int n);
        check({name, "_count"}, obs_cause_q.size(), n);
        if (n >= 1 && obs_cause_q.size() >= 1) check({name, "_c0"}, obs_cause_q[0], c0);
        if (n >= 2 && obs_cause_q.size() >= 2) check({name, "_c1"}, obs_cause_q[1], c1);
    endtask

    task automatic expect_redir0(input string name, input logic [31:0] pc);
        check({name, "_redir_present"}, {31'd0, obs_redir_q.size() >= 1}, 32'd1);
        if (obs_redir_q.size() >= 1) check({name, "_redir0"}, obs_redir_q[0], pc);
    endtask

    task automatic check_drained(input string name);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    logic [31:0] vec_ext_exp;

    // ---------------- stimulus ----------------
    initial begin
        tick(3);
        #2 iRST = 1'b1;

        // Exception: cause 2, tval DEADBEEF, PC 0x400010, UTVEC 0x400100.
        do_reset();
        iUTVEC = 32'h0040_0100;
        pulse_exc(5'd2, 32'hDEAD_BEEF, 32'h0040_0010);
        tick(5);
        expect_causes("exc_basic", 32'd2, 32'd0, 1);
        expect_redir0("exc_basic", 32'h0040_0100);
        check("exc_basic_handler", {31'd0, oInHandler}, 32'd1);
        do_uret(32'h0040_0014);
        tick(3);
        check("uret_leaves_handler", {31'd0, oInHandler}, 32'd0);
        check_drained("exc_basic");

        // Simultaneous ext+timer edges with UIE=1: ext first, timer after URET.
        do_reset();
        iUTVEC = 32'h0040_0100; iUSTATUS = 32'd1; iPC = 32'h0000_2000;
        @(negedge iCLK);
        iExtIrq = 1; iTimerIrq = 1;
        tick(8);
        expect_causes("irq_prio", 32'h8000_0008, 32'd0, 1);
        do_uret(32'h0000_2000);
        tick(8);
        expect_causes("irq_prio", 32'h8000_0008, 32'h8000_0004, 2);
        if (obs_redir_q.size() >= 2) check("irq_prio_uret_pc", obs_redir_q[1], 32'h0000_2000);
        do_uret(32'h0000_2004);
        tick(3);
        check_drained("irq_prio");

        // UIE=0 timer pulse stays pending until UIE is set.
        do_reset();
        iUTVEC = 32'h0040_0100;
        @(negedge iCLK); iTimerIrq = 1;
        @(negedge iCLK); iTimerIrq = 0;
        tick(6);
        expect_causes("masked_tmr", 32'd0, 32'd0, 0);
        iUSTATUS = 32'd1;
        tick(6);
        expect_causes("masked_tmr", 32'h8000_0004, 32'd0, 1);
        check_drained("masked_tmr");

        // Exception and URET together: trap wins. Then a nested exception overwrites.
        do_reset();
        iUTVEC = 32'h0040_0200;
        @(negedge iCLK);
        iExcReq = 1; iUret = 1; iExcCause = 5'd5; iExcTval = 32'h1111_2222;
        iPC = 32'h0000_3000; iUEPC = 32'h0000_9999;
        @(negedge iCLK);
        iExcReq = 0; iUret = 0;
        tick(5);
        expect_causes("exc_uret", 32'd5, 32'd0, 1);
        expect_redir0("exc_uret", 32'h0040_0200);
        check("exc_uret_redirects", obs_redir_q.size(), 1);
        pulse_exc(5'd7, 32'h3333_4444, 32'h0040_0204);
        tick(5);
        expect_causes("nested", 32'd5, 32'd7, 2);
        check_drained("nested");

        // Reset during CAPTURE aborts the trap.
        do_reset();
        iUTVEC = 32'h0040_0100;
        @(negedge iCLK);
        iExcReq = 1; iExcCause = 5'd3; iPC = 32'h0000_4000;
        @(negedge iCLK);
        iExcReq = 0;
        #2 iRST = 1'b0;
        tick(2);
        #2 iRST = 1'b1;
        obs_redir_q.delete();
        tick(5);
        check("abort_no_redirect", obs_redir_q.size(), 0);
        check("abort_state_idle", {30'd0, oDbgState}, 32'd0);
        check_drained("abort");

        // IRQ line high across reset release counts as an edge.
        @(negedge iCLK);
        #2 iRST = 1'b0;
        iExtIrq = 1; iUSTATUS = 32'd1;
        tick(2);
        #2 iRST = 1'b1;
        obs_cause_q.delete();
        tick(6);
        expect_causes("irq_at_release", 32'h8000_0008, 32'd0, 1);
        check_drained("irq_at_release");

        // Vectored mode bits: interrupt vs exception target.
        do_reset();
        iUTVEC = 32'h0040_0101; iUSTATUS = 32'd1;
        @(negedge iCLK); iExtIrq = 1;
        tick(6);
`ifdef VECTORED_INT_EN
        vec_ext_exp = 32'h0040_0120;
`else
        vec_ext_exp = 32'h0040_0100;
`endif
        expect_redir0("vec_ext", vec_ext_exp);
        do_uret(32'h0000_5000);
        tick(2);
        obs_redir_q.delete();
        pulse_exc(5'd1, 32'd0, 32'h0000_5000);
        tick(5);
        expect_redir0("vec_exc", 32'h0040_0100);
        check_drained("vec");

        // Randomized traffic against the model.
        do_reset();
        iUTVEC = {$urandom, 2'b00} | 32'($urandom_range(0, 1));
        for (int i = 0; i < 600; i++) begin
            @(negedge iCLK);
            iExcReq   = ($urandom_range(0, 9) == 0);
            iUret     = ($urandom_range(0, 6) == 0);
            iExcCause = 5'($urandom);
            iExcTval  = $urandom;
            iPC       = $urandom;
            iUEPC     = $urandom;
            if ($urandom_range(0, 5) == 0) iExtIrq = ~iExtIrq;
            if ($urandom_range(0, 5) == 0) iTimerIrq = ~iTimerIrq;
            if ($urandom_range(0, 19) == 0) iUSTATUS = {$urandom, 1'b0} | 32'(~iUSTATUS[0]);
        end
        @(negedge iCLK);
        iExcReq = 0; iUret = 0; iUSTATUS = 0;
        tick(8);
        check_drained("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
